survivor_mem: RTL and testbench

SURVIVOR_MEM -- requirements
Module: survivor_mem

---
 rtl/viterbi_pkg.sv | 10 +
 rtl/surv_ram.sv | 55 +++++
 rtl/survivor_mem.sv | 83 ++++++++
 tb/tb_survivor_mem.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder constants: default state width, traceback depth and derived widths.
package viterbi_pkg;

    localparam int unsigned DEF_M      = 6;
    localparam int unsigned DEF_D      = 40;
    localparam int unsigned DEF_NS     = 1 << DEF_M;
    localparam int unsigned DEF_PTR_W  = $clog2(DEF_D);
    localparam int unsigned DEF_FILL_W = $clog2(DEF_D + 1);

endpackage

// File: rtl/surv_ram.sv
// D x NS survivor storage: one write port, one registered single-bit read port.
// SURV_MEM_FWD_EN selects write-first on a same-cycle read/write collision; default is read-first.
module surv_ram
    import viterbi_pkg::*;
#(
    parameter  int unsigned M     = DEF_M,
    parameter  int unsigned D     = DEF_D,
    localparam int unsigned NS    = 1 << M,
    localparam int unsigned PTR_W = $clog2(D)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [NS-1:0]    wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    input  logic [M-1:0]     rsel_i,
    output logic             rdata_o
);

    logic [NS-1:0] mem_q [D];
    logic          rdata_q;
    logic          rdata_d;

    // Storage is never reset; only written columns are meaningful.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Out-of-range columns read as zero without touching the array.
    always_comb begin
        rdata_d = 1'b0;
        if (32'(raddr_i) < D) begin
            rdata_d = mem_q[raddr_i][rsel_i];
        end
`ifdef SURV_MEM_FWD_EN
        if (we_i && (raddr_i == waddr_i)) begin
            rdata_d = wdata_i[rsel_i];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/survivor_mem.sv
// Circular survivor-column store for Viterbi traceback: write pointer, fill level, flush handling.
// Collision behaviour follows surv_ram (macro SURV_MEM_FWD_EN enables write-first).
module survivor_mem
    import viterbi_pkg::*;
#(
    parameter  int unsigned M      = DEF_M,
    parameter  int unsigned D      = DEF_D,
    localparam int unsigned NS     = 1 << M,
    localparam int unsigned PTR_W  = $clog2(D),
    localparam int unsigned FILL_W = $clog2(D + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              surv_valid,
    input  logic [NS-1:0]     surv_vec,
    input  logic              flush,
    output logic [PTR_W-1:0]  wr_ptr,
    output logic [FILL_W-1:0] fill,
    output logic              tb_ready,
    input  logic [PTR_W-1:0]  tb_time,
    input  logic [M-1:0]      tb_state,
    output logic              tb_surv_bit
);

    localparam logic [PTR_W-1:0]  LAST_COL = PTR_W'(D - 1);
    localparam logic [FILL_W-1:0] FULL     = FILL_W'(D);

    logic [PTR_W-1:0]  nwr_q,    nwr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0] fill_q,   fill_d;
    logic              wr_en_c;

    // Flush drops the incoming column; reset aborts any pending write.
    assign wr_en_c = surv_valid & ~flush & ~rst;

    always_comb begin
        nwr_d    = nwr_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        if (flush) begin
            nwr_d    = '0;
            wr_ptr_d = LAST_COL;
            fill_d   = '0;
        end else if (surv_valid) begin
            wr_ptr_d = nwr_q;
            nwr_d    = (nwr_q == LAST_COL) ? '0 : nwr_q + PTR_W'(1);
            if (fill_q != FULL) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nwr_q    <= '0;
            wr_ptr_q <= LAST_COL;
            fill_q   <= '0;
        end else begin
            nwr_q    <= nwr_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
        end
    end

    assign wr_ptr   = wr_ptr_q;
    assign fill     = fill_q;
    assign tb_ready = (fill_q == FULL);

    surv_ram #(
        .M (M),
        .D (D)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_en_c),
        .waddr_i (nwr_q),
        .wdata_i (surv_vec),
        .raddr_i (tb_time),
        .rsel_i  (tb_state),
        .rdata_o (tb_surv_bit)
    );

endmodule

// File: tb/tb_survivor_mem.sv
// Bench for survivor_mem: behavioural column-store model checked every cycle plus directed literal checks.
module tb_survivor_mem;

    localparam int D  = 40;
    localparam int M  = 6;
    localparam int NS = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          surv_valid = 1'b0;
    logic [NS-1:0] surv_vec = '0;
    logic          flush = 1'b0;
    logic [5:0]    wr_ptr;
    logic [5:0]    fill;
    logic          tb_ready;
    logic [5:0]    tb_time = 6'd45;
    logic [M-1:0]  tb_state = '0;
    logic          tb_surv_bit;

    int n_assert = 0;
    int n_fail   = 0;

    survivor_mem #(.M(M), .D(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .surv_valid  (surv_valid),
        .surv_vec    (surv_vec),
        .flush       (flush),
        .wr_ptr      (wr_ptr),
        .fill        (fill),
        .tb_ready    (tb_ready),
        .tb_time     (tb_time),
        .tb_state    (tb_state),
        .tb_surv_bit (tb_surv_bit)
    );

    always #5 clk = ~clk;

    // Model: column queue semantics from the rules, using integers and a plain array.
    logic [NS-1:0] m_mem [D];
    bit            m_vld [D];
    int            m_nwr, m_wr_ptr, m_fill;
    bit            m_bit, m_bit_known, m_live = 0;
    bit            m_do_wr;

    always @(posedge clk) begin
        if (rst) begin
            m_nwr = 0; m_wr_ptr = D - 1; m_fill = 0;
            m_bit = 0; m_bit_known = 1; m_live = 1;
        end else if (m_live) begin
            m_do_wr = surv_valid && !flush;
            if (int'(tb_time) >= D) begin
                m_bit = 0; m_bit_known = 1;
            end else if (m_do_wr && int'(tb_time) == m_nwr) begin
`ifdef SURV_MEM_FWD_EN
                m_bit = surv_vec[tb_state]; m_bit_known = 1;
`else
                m_bit = m_mem[tb_time][tb_state]; m_bit_known = m_vld[tb_time];
`endif
            end else begin
                m_bit = m_mem[tb_time][tb_state]; m_bit_known = m_vld[tb_time];
            end
            if (flush) begin
                m_nwr = 0; m_wr_ptr = D - 1; m_fill = 0;
            end else if (m_do_wr) begin
                m_mem[m_nwr] = surv_vec;
                m_vld[m_nwr] = 1;
                m_wr_ptr = m_nwr;
                m_nwr = (m_nwr + 1) % D;
                if (m_fill < D) m_fill = m_fill + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model on the inactive edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("wr_ptr", int'(wr_ptr), m_wr_ptr);
            chk("fill", int'(fill), m_fill);
            chk("tb_ready", int'(tb_ready), (m_fill == D) ? 1 : 0);
            if (m_bit_known) chk("tb_surv_bit", int'(tb_surv_bit), int'(m_bit));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [NS-1:0] vec);
        surv_valid = 1'b1;
        surv_vec   = vec;
        step();
        surv_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        logic [NS-1:0] one;
        one = '0;
        one[17] = 1'b1;

        // Reset state
        step(); step();
        rst = 1'b0;
        chk("rst_wr_ptr", int'(wr_ptr), 39);
        chk("rst_fill", int'(fill), 0);
        chk("rst_ready", int'(tb_ready), 0);
        chk("rst_bit", int'(tb_surv_bit), 0);

        // Fill and wrap: column i holds i
        for (int i = 0; i < D; i++) wr(NS'(i));
        chk("full_fill", int'(fill), 40);
        chk("full_ready", int'(tb_ready), 1);
        chk("full_wr_ptr", int'(wr_ptr), 39);
        wr(NS'(40));
        chk("wrap_wr_ptr", int'(wr_ptr), 0);
        chk("wrap_fill", int'(fill), 40);
        tb_time = 6'd0; tb_state = 6'd3; step();
        chk("col0_b3", int'(tb_surv_bit), 1);
        tb_state = 6'd5; step();
        chk("col0_b5", int'(tb_surv_bit), 1);
        tb_state = 6'd0; step();
        chk("col0_b0", int'(tb_surv_bit), 0);
        tb_time = 6'd39; tb_state = 6'd0; step();
        chk("col39_b0", int'(tb_surv_bit), 1);
        tb_state = 6'd3; step();
        chk("col39_b3", int'(tb_surv_bit), 0);

        // Read latency: column 5 holds only bit 17
        do_flush();
        chk("flush_fill", int'(fill), 0);
        chk("flush_wr_ptr", int'(wr_ptr), 39);
        for (int i = 0; i < 6; i++) wr((i == 5) ? one : '0);
        tb_time = 6'd5; tb_state = 6'd17;
        chk("lat_pre", int'(tb_surv_bit), 0);
        step();
        chk("lat_b17", int'(tb_surv_bit), 1);
        tb_state = 6'd16; step();
        chk("lat_b16", int'(tb_surv_bit), 0);

        // Collision: all-ones written to column 3 while reading it
        do_flush();
        for (int i = 0; i < 3; i++) wr('0);
        tb_time = 6'd3; tb_state = 6'd9;
        wr('1);
`ifdef SURV_MEM_FWD_EN
        chk("collide", int'(tb_surv_bit), 1);
`else
        chk("collide", int'(tb_surv_bit), 0);
`endif
        step();
        chk("after_collide", int'(tb_surv_bit), 1);

        // Flush beats a simultaneous write at fill=25
        do_flush();
        for (int i = 0; i < 25; i++) wr(NS'(32'hA5A5_0000 | i));
        chk("fill25", int'(fill), 25);
        flush = 1'b1; surv_valid = 1'b1; surv_vec = '1;
        step();
        flush = 1'b0; surv_valid = 1'b0;
        chk("fw_fill", int'(fill), 0);
        chk("fw_wr_ptr", int'(wr_ptr), 39);
        chk("fw_ready", int'(tb_ready), 0);
        tb_time = 6'd25; tb_state = 6'd1; step();
        chk("fw_dropped", int'(tb_surv_bit), 0);
        wr(NS'(7));
        chk("fw_nwr0", int'(wr_ptr), 0);
        chk("fw_fill1", int'(fill), 1);

        // Out of range
        tb_time = 6'd45; tb_state = 6'd0; step();
        chk("oor45", int'(tb_surv_bit), 0);
        tb_time = 6'd63; step();
        chk("oor63", int'(tb_surv_bit), 0);

        // Reset aborts a pending write to column 1
        rst = 1'b1; surv_valid = 1'b1; surv_vec = '1;
        step();
        rst = 1'b0; surv_valid = 1'b0;
        chk("mrst_wr_ptr", int'(wr_ptr), 39);
        chk("mrst_fill", int'(fill), 0);
        chk("mrst_bit", int'(tb_surv_bit), 0);
        tb_time = 6'd1; tb_state = 6'd2; step();
        chk("mrst_no_write", int'(tb_surv_bit), 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
